multicycle_cpu: RTL and testbench
=================================

Name: multicycle_cpu

Overview:
Parametrised multi-cycle successor to the team's single-cycle 8-bit CPU. It keeps the 2-bit-opcode ISA (ADDI, SLLI, JMP) and adds a conditional branch, BEQZ. Instructions are fetched over a valid/request handshake from an external instruction memory, so wait states are tolerated. Each instruction runs through a FETCH/EXEC/WB state machine, and one retire pulse is produced per instruction.

Parameters:
DATA_W, 8, register/datapath width in bits
PC_W, 8, program counter and instruction address width
REG_ADDR_W, 3, register index width; register file holds 2**REG_ADDR_W registers
IMM_W, 3, immediate field width for ADDI/SLLI/BEQZ
(localparam INSTR_W = 2 + REG_ADDR_W + IMM_W; default 8)

Ports:
Clk  input  1  clock; all state changes on the rising edge
Reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request; high only in FETCH
imem_addr  output  PC_W  fetch address; equals pc while imem_req is high
imem_valid  input  1  instruction data valid; sampled only while imem_req=1
imem_rdata  input  INSTR_W  instruction word
pc  output  PC_W  current program counter
retire  output  1  high for exactly the WB cycle of each instruction
dbg_sel  input  REG_ADDR_W  debug register select
dbg_data  output  DATA_W  combinational read of register dbg_sel

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high; it dominates every other event.
- Reset effects, at the next edge: pc=0, all registers=0, IR=0, state=FETCH. imem_req, and therefore retire, read 0 during the reset cycle.
- Instruction fields: op=IR[INSTR_W-1:INSTR_W-2], rd=IR[INSTR_W-3:IMM_W], imm=IR[IMM_W-1:0], off=IR[INSTR_W-3:0].
- op 00, ADDI: rd <= rd + sext(imm), modulo 2**DATA_W; pc <= pc+1.
- op 01, SLLI: rd <= rd << imm, with imm read as unsigned; the result is 0 when imm >= DATA_W; pc <= pc+1.
- op 10, JMP: pc <= pc + 1 + sext(off). No register write.
- op 11, BEQZ: if rd == 0, pc <= pc + 1 + sext(imm); otherwise pc <= pc+1. No register write.
- PC arithmetic: modulo 2**PC_W, so wrap-around from max to 0 is legal. sext widens to PC_W, or truncates if PC_W is narrower.
- State FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_valid=1.
  - On an edge with imem_valid=1, IR <= imem_rdata and state -> EXEC.
  - If imem_valid=0, stay in FETCH indefinitely; there is no timeout.
- State EXEC: latch the ALU result and the next-pc value; state -> WB. imem_req=0.
- State WB: retire=1; the register write and pc update commit at the end of this cycle; state -> FETCH.
- Latency: 3 cycles per instruction with zero-wait memory (FETCH, EXEC, WB), plus one cycle per wait state.
- imem_valid while imem_req=0 is ignored.
- Reset during FETCH wait, EXEC or WB aborts the instruction with no architectural update; imem_req is 0 the cycle after reset.
- dbg_data shows the old register value during WB and the new value from the following cycle.
- retire is decoded from the state register (Moore), so it is glitch-free.

Test Plan:
1. Reset, then fetch 0x0B (ADDI r1,+3) with zero-wait memory -> retire in cycle 3 after FETCH entry; dbg_sel=1 gives 0x03; pc=1.
2. From reset, ADDI r1,-1 (0x0F) -> r1=0xFF. Then SLLI r2,2 (0x52) with r2=0x03 -> r2=0x0C. SLLI r2,7 (0x57) with r2=0x03 -> r2=0x80.
3. JMP:
   - At pc=0, JMP +2 (0x82) -> pc=3.
   - At pc=5, JMP -1 (0xBF) -> pc=5 (self-loop, repeated fetch of address 5).
   - At pc=0xFF, JMP 0 (0x80) -> pc wraps to 0x00.
4. BEQZ r3,+2 (0xDA):
   - With r3=0 at pc=4 -> pc=7.
   - With r3=1 at pc=4 -> pc=5.
   - No register changes in either case.
5. Hold imem_valid low for 3 cycles during FETCH -> imem_req=1 and imem_addr constant throughout, no retire; pulse imem_valid while in EXEC -> ignored.
6. Assert Reset during a FETCH wait and again during WB of ADDI r1,+3 -> pc=0, r1=0, no retire; imem_req=0 in the cycle after reset, then FETCH resumes at address 0.

Source files
------------

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle CPU with a 2-bit-opcode ISA (ADDI, SLLI, JMP, BEQZ).
// Each instruction runs FETCH -> EXEC -> WB. Instructions are fetched over a
// req/valid handshake, so the instruction memory may insert wait states.
module multicycle_cpu #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PC_W       = 8,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned IMM_W      = 3,
    localparam int unsigned INSTR_W   = 2 + REG_ADDR_W + IMM_W
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic                  imem_valid,
    input  logic [INSTR_W-1:0]    imem_rdata,
    output logic [PC_W-1:0]       pc,
    output logic                  retire,
    input  logic [REG_ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
    localparam int unsigned OFF_W    = INSTR_W - 2;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]    alu_q, alu_d;
    logic [PC_W-1:0]      npc_q, npc_d;
    logic                 req_q, req_d;
    logic                 retire_q, retire_d;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [DATA_W-1:0]    regs_d [NUM_REGS];

    logic [1:0]            op;
    logic [REG_ADDR_W-1:0] rd;
    logic [IMM_W-1:0]      imm;
    logic [OFF_W-1:0]      off;
    logic [DATA_W-1:0]     rd_val;
    logic [PC_W-1:0]       pc_inc;

    // Instruction field decode from the latched instruction register
    assign op     = ir_q[INSTR_W-1:INSTR_W-2];
    assign rd     = ir_q[INSTR_W-3:IMM_W];
    assign imm    = ir_q[IMM_W-1:0];
    assign off    = ir_q[INSTR_W-3:0];
    assign rd_val = regs_q[rd];
    assign pc_inc = pc_q + PC_W'(1);

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign retire    = retire_q;
    assign dbg_data  = regs_q[dbg_sel];

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; valid is only honoured while a request is outstanding
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (req_q && imem_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Output and datapath next values; req/retire follow the next state so they are Moore flops
    always_comb begin
        req_d    = (state_d == S_FETCH);
        retire_d = (state_d == S_WB);
        pc_d     = pc_q;
        ir_d     = ir_q;
        alu_d    = alu_q;
        npc_d    = npc_q;
        regs_d   = regs_q;
        case (state_q)
            S_FETCH: begin
                if (req_q && imem_valid) ir_d = imem_rdata;
            end
            S_EXEC: begin
                case (op)
                    2'b00: begin
                        alu_d = rd_val + DATA_W'($signed(imm));
                        npc_d = pc_inc;
                    end
                    2'b01: begin
                        alu_d = (32'(imm) >= DATA_W) ? '0 : (rd_val << imm);
                        npc_d = pc_inc;
                    end
                    2'b10: begin
                        npc_d = pc_inc + PC_W'($signed(off));
                    end
                    default: begin
                        npc_d = (rd_val == '0) ? (pc_inc + PC_W'($signed(imm))) : pc_inc;
                    end
                endcase
            end
            S_WB: begin
                pc_d = npc_q;
                if (!op[1]) regs_d[rd] = alu_q;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any in-flight instruction
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            alu_q    <= '0;
            npc_q    <= '0;
            req_q    <= 1'b0;
            retire_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            alu_q    <= alu_d;
            npc_q    <= npc_d;
            req_q    <= req_d;
            retire_q <= retire_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Testbench for multicycle_cpu: directed scenarios plus randomized programs
// checked against an arithmetic model of the instruction set.
module tb_multicycle_cpu;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic [7:0] pc;
    logic       retire;
    logic [2:0] dbg_sel = 3'd0;
    logic [7:0] dbg_data;

    int checks = 0;
    int passed = 0;

    int m_regs [8];
    int m_pc;

    multicycle_cpu dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .retire     (retire),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc = 0;
    endtask

    // ISA rules in plain integer arithmetic, 8-bit wrap everywhere
    task automatic model_exec(input logic [7:0] instr);
        int op, r, im, of, sim, sof;
        op  = int'(instr[7:6]);
        r   = int'(instr[5:3]);
        im  = int'(instr[2:0]);
        of  = int'(instr[5:0]);
        sim = (im >= 4) ? im - 8 : im;
        sof = (of >= 32) ? of - 64 : of;
        case (op)
            0: begin m_regs[r] = (m_regs[r] + sim) & 255; m_pc = (m_pc + 1) & 255; end
            1: begin m_regs[r] = (im >= 8) ? 0 : ((m_regs[r] << im) & 255); m_pc = (m_pc + 1) & 255; end
            2: m_pc = (m_pc + 1 + sof) & 255;
            default: m_pc = (m_regs[r] == 0) ? ((m_pc + 1 + sim) & 255) : ((m_pc + 1) & 255);
        endcase
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        imem_valid = 1'b0;
        tick();
        Reset = 1'b0;
        model_reset();
    endtask

    // Drive one instruction through the handshake; reports latency, handshake stability and WB-cycle dbg value
    task automatic run_instr(input logic [7:0] instr, input int waits, input bit pulse_exec,
                             output int lat, output bit ok, output bit stable, output logic [7:0] wb_dbg);
        int n;
        logic [7:0] addr0;
        ok = 1'b1; stable = 1'b1; lat = 0; wb_dbg = 8'h00; n = 0;
        while (imem_req !== 1'b1 && n < 20) begin tick(); n++; end
        if (imem_req !== 1'b1) begin ok = 1'b0; return; end
        addr0 = imem_addr;
        imem_valid = 1'b0;
        for (int w = 0; w < waits; w++) begin
            tick(); lat++;
            if (imem_req !== 1'b1 || imem_addr !== addr0 || retire !== 1'b0) stable = 1'b0;
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        tick(); lat++;
        imem_valid = 1'b0;
        imem_rdata = 8'($urandom);
        if (imem_req !== 1'b0) stable = 1'b0;
        if (pulse_exec) imem_valid = 1'b1;
        n = 0;
        while (retire !== 1'b1 && n < 10) begin tick(); lat++; n++; imem_valid = 1'b0; end
        imem_valid = 1'b0;
        if (retire !== 1'b1) begin ok = 1'b0; return; end
        wb_dbg = dbg_data;
        tick();
        if (retire !== 1'b0) stable = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        checks++; if (imem_req !== 1'b0 || retire !== 1'b0) $display("FAIL reset_outputs: req=%0b retire=%0b want 0 0", imem_req, retire); else passed++;
        checks++; if (pc !== 8'h00) $display("FAIL reset_pc: got %0h want 0", pc); else passed++;
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i); #1;
            checks++; if (dbg_data !== 8'h00) $display("FAIL reset_reg%0d: got %0h want 0", i, dbg_data); else passed++;
        end
        Reset = 1'b0;
        model_reset();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL reset_resume: req=%0b addr=%0h want 1 0", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_addi();
        int lat; bit ok, st; logic [7:0] wbd;
        do_reset();
        dbg_sel = 3'd1;
        run_instr(8'h0B, 0, 1'b0, lat, ok, st, wbd);
        model_exec(8'h0B);
        checks++; if (!ok || !st || lat !== 2) $display("FAIL addi_latency: ok=%0b stable=%0b lat=%0d want 1 1 2", ok, st, lat); else passed++;
        checks++; if (wbd !== 8'h00) $display("FAIL addi_wb_old: got %0h want 0", wbd); else passed++;
        checks++; if (dbg_data !== 8'h03 || dbg_data !== 8'(m_regs[1])) $display("FAIL addi_r1: got %0h want 03", dbg_data); else passed++;
        checks++; if (pc !== 8'h01) $display("FAIL addi_pc: got %0h want 01", pc); else passed++;
        run_instr(8'h0F, 0, 1'b0, lat, ok, st, wbd);
        model_exec(8'h0F);
        checks++; if (!ok || dbg_data !== 8'h02) $display("FAIL addi_neg: got %0h want 02", dbg_data); else passed++;
        do_reset();
        run_instr(8'h0F, 0, 1'b0, lat, ok, st, wbd);
        checks++; if (!ok || dbg_data !== 8'hFF) $display("FAIL addi_minus1: got %0h want ff", dbg_data); else passed++;
    endtask

    task automatic test_slli();
        int lat; bit ok, st; logic [7:0] wbd;
        logic [7:0] prog [2];
        logic [7:0] want [2];
        prog[0] = 8'h52; want[0] = 8'h0C;
        prog[1] = 8'h57; want[1] = 8'h80;
        dbg_sel = 3'd2;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            run_instr(8'h13, 0, 1'b0, lat, ok, st, wbd);
            run_instr(prog[k], 0, 1'b0, lat, ok, st, wbd);
            checks++; if (!ok || dbg_data !== want[k]) $display("FAIL slli_%0d: got %0h want %0h", k, dbg_data, want[k]); else passed++;
        end
    endtask

    task automatic test_jmp();
        int lat; bit ok, st; logic [7:0] wbd;
        do_reset();
        run_instr(8'h82, 0, 1'b0, lat, ok, st, wbd);
        checks++; if (!ok || pc !== 8'h03) $display("FAIL jmp_fwd: got %0h want 03", pc); else passed++;
        do_reset();
        run_instr(8'h84, 0, 1'b0, lat, ok, st, wbd);
        run_instr(8'hBF, 0, 1'b0, lat, ok, st, wbd);
        checks++; if (!ok || pc !== 8'h05) $display("FAIL jmp_self1: got %0h want 05", pc); else passed++;
        run_instr(8'hBF, 0, 1'b0, lat, ok, st, wbd);
        checks++; if (!ok || pc !== 8'h05 || imem_addr !== 8'h05) $display("FAIL jmp_self2: pc=%0h addr=%0h want 05", pc, imem_addr); else passed++;
        do_reset();
        run_instr(8'hBE, 0, 1'b0, lat, ok, st, wbd);
        checks++; if (!ok || pc !== 8'hFF) $display("FAIL jmp_to_ff: got %0h want ff", pc); else passed++;
        run_instr(8'h80, 0, 1'b0, lat, ok, st, wbd);
        checks++; if (!ok || pc !== 8'h00) $display("FAIL jmp_wrap: got %0h want 00", pc); else passed++;
    endtask

    task automatic test_beqz();
        int lat; bit ok, st; logic [7:0] wbd;
        logic [7:0] snap [8];
        do_reset();
        run_instr(8'h83, 0, 1'b0, lat, ok, st, wbd);
        run_instr(8'hDA, 0, 1'b0, lat, ok, st, wbd);
        checks++; if (!ok || pc !== 8'h07) $display("FAIL beqz_taken: got %0h want 07", pc); else passed++;
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i); #1;
            checks++; if (dbg_data !== 8'h00) $display("FAIL beqz_taken_r%0d: got %0h want 0", i, dbg_data); else passed++;
        end
        do_reset();
        run_instr(8'h19, 0, 1'b0, lat, ok, st, wbd);
        run_instr(8'h82, 0, 1'b0, lat, ok, st, wbd);
        for (int i = 0; i < 8; i++) begin dbg_sel = 3'(i); #1; snap[i] = dbg_data; end
        run_instr(8'hDA, 0, 1'b0, lat, ok, st, wbd);
        checks++; if (!ok || pc !== 8'h05) $display("FAIL beqz_not_taken: got %0h want 05", pc); else passed++;
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i); #1;
            checks++; if (dbg_data !== snap[i] || (i == 3 && dbg_data !== 8'h01)) $display("FAIL beqz_nt_r%0d: got %0h want %0h", i, dbg_data, snap[i]); else passed++;
        end
    endtask

    task automatic test_wait();
        int lat; bit ok, st; logic [7:0] wbd;
        do_reset();
        dbg_sel = 3'd1;
        run_instr(8'h0B, 3, 1'b1, lat, ok, st, wbd);
        checks++; if (!ok || !st) $display("FAIL wait_handshake: ok=%0b stable=%0b want 1 1", ok, st); else passed++;
        checks++; if (lat !== 5) $display("FAIL wait_latency: got %0d want 5", lat); else passed++;
        checks++; if (dbg_data !== 8'h03 || pc !== 8'h01) $display("FAIL wait_result: r1=%0h pc=%0h want 03 01", dbg_data, pc); else passed++;
    endtask

    task automatic test_reset_abort();
        int lat, n; bit ok, st; logic [7:0] wbd;
        do_reset();
        dbg_sel = 3'd1;
        run_instr(8'h82, 0, 1'b0, lat, ok, st, wbd);
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin tick(); n++; end
        imem_valid = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (imem_req !== 1'b0 || retire !== 1'b0 || pc !== 8'h00) $display("FAIL abort_fetch: req=%0b retire=%0b pc=%0h want 0 0 0", imem_req, retire, pc); else passed++;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL abort_fetch_resume: req=%0b addr=%0h want 1 0", imem_req, imem_addr); else passed++;
        run_instr(8'h82, 0, 1'b0, lat, ok, st, wbd);
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin tick(); n++; end
        imem_valid = 1'b1; imem_rdata = 8'h0B;
        tick();
        imem_valid = 1'b0;
        tick();
        checks++; if (retire !== 1'b1) $display("FAIL abort_wb_reached: retire=%0b want 1", retire); else passed++;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (retire !== 1'b0 || imem_req !== 1'b0 || pc !== 8'h00 || dbg_data !== 8'h00) $display("FAIL abort_wb: retire=%0b req=%0b pc=%0h r1=%0h want 0 0 0 0", retire, imem_req, pc, dbg_data); else passed++;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || dbg_data !== 8'h00) $display("FAIL abort_wb_resume: req=%0b addr=%0h r1=%0h want 1 0 0", imem_req, imem_addr, dbg_data); else passed++;
        model_reset();
    endtask

    task automatic test_random();
        int lat, waits, old; bit ok, st; logic [7:0] wbd, instr;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            instr = 8'($urandom);
            waits = int'($urandom_range(0, 2));
            dbg_sel = 3'($urandom);
            old = m_regs[dbg_sel];
            run_instr(instr, waits, 1'($urandom), lat, ok, st, wbd);
            model_exec(instr);
            checks++; if (!ok || !st || lat !== waits + 2) $display("FAIL rand_handshake[%0d]: ok=%0b stable=%0b lat=%0d want lat %0d", k, ok, st, lat, waits + 2); else passed++;
            checks++; if (pc !== 8'(m_pc)) $display("FAIL rand_pc[%0d]: instr=%0h got %0h want %0h", k, instr, pc, m_pc); else passed++;
            checks++; if (wbd !== 8'(old) || dbg_data !== 8'(m_regs[dbg_sel])) $display("FAIL rand_reg[%0d]: r%0d wb=%0h now=%0h want %0h %0h", k, dbg_sel, wbd, dbg_data, old, m_regs[dbg_sel]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_slli();
        test_jmp();
        test_beqz();
        test_wait();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
